// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
//   Shared definitions for the two-master AHB-Lite arbiter:
//   - HTRANS encodings
//   - master-id type (M0 = 0, M1 = 1)
//   - data-phase owner encoding (NONE / M0 / M1)
`timescale 1ns/1ps
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef logic mid_t;
  localparam mid_t MID_M0 = 1'b0;
  localparam mid_t MID_M1 = 1'b1;

  typedef enum logic [1:0] {
    DOWNER_NONE = 2'd0,
    DOWNER_M0   = 2'd1,
    DOWNER_M1   = 2'd2
  } downer_e;

  function automatic downer_e mid_to_downer(input mid_t m);
    return (m == MID_M1) ? DOWNER_M1 : DOWNER_M0;
  endfunction

endpackage

// File: rtl/ahblite_arb_input_stage.sv
// ahblite_arb_input_stage
//   Per-master hold register plus source mux. An address phase that the
//   master believes was accepted, but that cannot go onto the shared bus in
//   the same cycle, is parked here until the arbiter issues it.
// Ports:
//   HCLK, HRESETn        clock, async active-low reset
//   haddr/htrans/hwrite/hsize   live address phase from the master
//   hready_m             HREADY currently presented to this master
//   granted              this master is the address-phase grantee this cycle
//   hready               HREADY from the interconnect
//   hold_valid           hold register occupied
//   src_*                address phase this master offers to the arbiter
`timescale 1ns/1ps
module ahblite_arb_input_stage (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hready_m,
  input  logic        granted,
  input  logic        hready,
  output logic        hold_valid,
  output logic [31:0] src_addr,
  output logic [1:0]  src_trans,
  output logic        src_write,
  output logic [2:0]  src_size
);
  import ahb_arb_pkg::*;

  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic        capture;
  logic        issued;

  // The master sampled HREADY high, so its address phase is accepted from
  // its point of view; keep a copy unless the bus takes it right now.
  // While the hold is full the master sees HREADY low, so a second capture
  // cannot overwrite a pending entry.
  assign capture = htrans[1] && hready_m && (!granted || !hready);
  assign issued  = hold_valid && granted && hready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= HTRANS_IDLE;
      hold_write <= 1'b0;
      hold_size  <= '0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_addr  <= haddr;
      hold_trans <= htrans;
      hold_write <= hwrite;
      hold_size  <= hsize;
    end else if (issued) begin
      hold_valid <= 1'b0;
    end
  end

  assign src_addr  = hold_valid ? hold_addr  : haddr;
  assign src_trans = hold_valid ? hold_trans : htrans;
  assign src_write = hold_valid ? hold_write : hwrite;
  assign src_size  = hold_valid ? hold_size  : hsize;

endmodule

// File: rtl/ahblite_master_arb2.sv
// ahblite_master_arb2
//   Shares one AHB-Lite bus between two masters (M0, M1). Each master has an
//   input stage that absorbs an address phase while the other owns the bus.
//   The grant is locked for the duration of a burst (SEQ/BUSY), the data-phase
//   owner steers HWDATA and the per-master HREADY, and HRDATA is broadcast.
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined: contention goes to the master that did not
//                       win the last NONSEQ; undefined: M0 always wins.
// Handshake: a master transfer is accepted in a cycle where it drives
//   HTRANS_Mx[1]=1 and sees HREADY_Mx=1; the shared bus follows plain
//   AHB-Lite (address accepted when HREADY=1, data one cycle later).
// Ports:
//   HCLK, HRESETn                     clock, async active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA_Mx   master x request
//   HRDATA_Mx, HREADY_Mx              responses to master x
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA  shared bus outputs
//   HRDATA, HREADY                    shared bus responses
`timescale 1ns/1ps
module ahblite_master_arb2 (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR_M0,
  input  logic [1:0]  HTRANS_M0,
  input  logic        HWRITE_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic [31:0] HWDATA_M0,
  output logic [31:0] HRDATA_M0,
  output logic        HREADY_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic [31:0] HRDATA_M1,
  output logic        HREADY_M1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);
  import ahb_arb_pkg::*;

  logic [31:0] src0_addr, src1_addr;
  logic [1:0]  src0_trans, src1_trans;
  logic        src0_write, src1_write;
  logic [2:0]  src0_size, src1_size;
  logic        hold0_valid, hold1_valid;

  mid_t        gnt_q, gnt, contend_winner;
  logic        hready_q;
  downer_e     downer_q;
  logic        req0, req1, lock, g_req;
  logic [1:0]  owner_trans, g_trans;

  ahblite_arb_input_stage u_stage0 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .haddr      (HADDR_M0),
    .htrans     (HTRANS_M0),
    .hwrite     (HWRITE_M0),
    .hsize      (HSIZE_M0),
    .hready_m   (HREADY_M0),
    .granted    (gnt == MID_M0),
    .hready     (HREADY),
    .hold_valid (hold0_valid),
    .src_addr   (src0_addr),
    .src_trans  (src0_trans),
    .src_write  (src0_write),
    .src_size   (src0_size)
  );

  ahblite_arb_input_stage u_stage1 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .haddr      (HADDR_M1),
    .htrans     (HTRANS_M1),
    .hwrite     (HWRITE_M1),
    .hsize      (HSIZE_M1),
    .hready_m   (HREADY_M1),
    .granted    (gnt == MID_M1),
    .hready     (HREADY),
    .hold_valid (hold1_valid),
    .src_addr   (src1_addr),
    .src_trans  (src1_trans),
    .src_write  (src1_write),
    .src_size   (src1_size)
  );

  assign req0        = src0_trans[1];
  assign req1        = src1_trans[1];
  assign owner_trans = (gnt_q == MID_M1) ? src1_trans : src0_trans;
  assign lock        = (owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
  mid_t last_q;
  assign contend_winner = ~last_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_q <= MID_M1;
    end else if (HREADY && (HTRANS == HTRANS_NONSEQ)) begin
      last_q <= gnt;
    end
  end
`else
  assign contend_winner = MID_M0;
`endif

  // The grant is decided combinationally at the start of each address phase
  // so a granted live transfer passes straight through. After an HREADY=0
  // cycle the previous grant is reused, keeping the extended address stable.
  always_comb begin
    gnt = gnt_q;
    if (hready_q && !lock) begin
      if (req0 && req1) begin
        gnt = contend_winner;
      end else if (req0) begin
        gnt = MID_M0;
      end else if (req1) begin
        gnt = MID_M1;
      end
    end
  end

  assign g_trans = (gnt == MID_M1) ? src1_trans : src0_trans;
  assign g_req   = g_trans[1];

  // BUSY from the lock owner is passed so the burst stays well formed.
  assign HTRANS = (g_req || lock) ? g_trans : HTRANS_IDLE;
  assign HADDR  = (gnt == MID_M1) ? src1_addr  : src0_addr;
  assign HWRITE = (gnt == MID_M1) ? src1_write : src0_write;
  assign HSIZE  = (gnt == MID_M1) ? src1_size  : src0_size;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q    <= MID_M0;
      hready_q <= 1'b1;
      downer_q <= DOWNER_NONE;
    end else begin
      gnt_q    <= gnt;
      hready_q <= HREADY;
      if (HREADY) begin
        downer_q <= HTRANS[1] ? mid_to_downer(gnt) : DOWNER_NONE;
      end
    end
  end

  always_comb begin
    HWDATA = '0;
    case (downer_q)
      DOWNER_M0: HWDATA = HWDATA_M0;
      DOWNER_M1: HWDATA = HWDATA_M1;
      default:   HWDATA = '0;
    endcase
  end

  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  // A master with a parked transfer is stalled until its data phase is due.
  assign HREADY_M0 = (downer_q == DOWNER_M0) ? HREADY : !hold0_valid;
  assign HREADY_M1 = (downer_q == DOWNER_M1) ? HREADY : !hold1_valid;

endmodule
